// File: rtl/regfl_rd_ser.sv
// Register-file read serializer: snapshots the flat register bus on start and
// streams a wrapped run of registers over valid/ready with a running checksum.
module regfl_rd_ser #(
  parameter  int unsigned W  = 64,
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [N*W-1:0] q,
  input  logic           start,
  input  logic [IW-1:0]  first,
  input  logic [IW:0]    cnt,
  input  logic           abort,
  output logic [W-1:0]   dout,
  output logic [IW-1:0]  dout_idx,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   chk
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  snap   [N];
  logic [W-1:0]  snap_n [N];
  logic [W-1:0]  qw     [N];
  logic [IW:0]   rem, rem_n, cnt_eff;
  logic [IW-1:0] idx_n, idx_inc;
  logic [W-1:0]  dout_n, chk_n;
  logic          valid_n, busy_n, done_n;

  // Register 0 sits in the most significant word of the flat bus.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) qw[i] = q[N*W-1-i*W -: W];
  end

  assign cnt_eff = (cnt == '0 || 32'(cnt) > N) ? (IW+1)'(N) : cnt;
  assign idx_inc = dout_idx + IW'(1);

  always_comb begin
    state_n = state;
    snap_n  = snap;
    rem_n   = rem;
    idx_n   = dout_idx;
    dout_n  = dout;
    valid_n = dout_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    chk_n   = chk;
    case (state)
      IDLE: begin
        if (start) begin
          snap_n  = qw;
          dout_n  = qw[first];
          idx_n   = first;
          rem_n   = cnt_eff;
          chk_n   = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        // Abort wins over a simultaneous handshake, so that word is not summed.
        if (abort) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (dout_ready) begin
          chk_n  = chk + dout;
          rem_n  = rem - (IW+1)'(1);
          idx_n  = idx_inc;
          dout_n = snap[idx_inc];
          if (rem == (IW+1)'(1)) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      snap       <= '{default: '0};
      rem        <= '0;
      dout_idx   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      chk        <= '0;
    end else begin
      state      <= state_n;
      snap       <= snap_n;
      rem        <= rem_n;
      dout_idx   <= idx_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
      chk        <= chk_n;
    end
  end

endmodule

// File: tb/tb_regfl_rd_ser.sv
// Bench for regfl_rd_ser: directed and random transfers checked against a
// queue-based model of the words each transfer should deliver.
module tb_regfl_rd_ser;

  logic         clk;
  logic         rst_b;
  logic [511:0] q;
  logic         start;
  logic [2:0]   first;
  logic [3:0]   cnt;
  logic         abort;
  logic [63:0]  dout;
  logic [2:0]   dout_idx;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         done;
  logic [63:0]  chk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] regs [8];

  regfl_rd_ser #(.W(64), .N(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .q          (q),
    .start      (start),
    .first      (first),
    .cnt        (cnt),
    .abort      (abort),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .chk        (chk)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, dout, 64'd0);
    check({tag, "_idx"}, {61'd0, dout_idx}, 64'd0);
    check({tag, "_valid"}, {63'd0, dout_valid}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_chk"}, chk, 64'd0);
  endtask

  task automatic load_q();
    for (int i = 0; i < 8; i++) q[511-i*64 -: 64] = regs[i];
  endtask

  task automatic set_incr();
    for (int i = 0; i < 8; i++) regs[i] = 64'(i + 1);
  endtask

  // mode: 0 ready held high, 1 ready from pat bits then high, 2 random ready.
  // abort_at: number of accepted words before abort is raised (-1 = never).
  task automatic run(input int fst, input int c, input int mode, input logic [15:0] pat,
                     input int abort_at, input bit disturb, input string tag);
    logic [63:0] exp_w [$];
    int          exp_i [$];
    logic [63:0] sum;
    int          n, acc, cyc;
    bit          rdy, fin;
    n = (c == 0 || c > 8) ? 8 : c;
    for (int k = 0; k < n; k++) begin
      exp_w.push_back(regs[(fst + k) % 8]);
      exp_i.push_back((fst + k) % 8);
    end
    sum = 64'd0; acc = 0; cyc = 0; fin = 1'b0;
    load_q();
    first = 3'(fst);
    cnt   = 4'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin) begin
      if (cyc > 64) begin
        check({tag, "_timeout"}, 64'd1, 64'd0);
        break;
      end
      check({tag, "_valid"}, {63'd0, dout_valid}, 64'd1);
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      check({tag, "_done_early"}, {63'd0, done}, 64'd0);
      check({tag, "_data"}, dout, exp_w[0]);
      check({tag, "_idx"}, {61'd0, dout_idx}, 64'(exp_i[0]));
      check({tag, "_chk_run"}, chk, sum);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc < 16) ? pat[cyc] : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dout_ready = rdy;
      if (disturb && cyc == 2) begin
        q     = '1;
        start = 1'b1;
      end
      if (acc == abort_at) begin
        abort      = 1'b1;
        dout_ready = 1'b1;
      end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; dout_ready = 1'b0;
      cyc++;
      if (acc == abort_at) begin
        check({tag, "_abort_valid"}, {63'd0, dout_valid}, 64'd0);
        check({tag, "_abort_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_abort_done"}, {63'd0, done}, 64'd0);
        check({tag, "_abort_chk"}, chk, sum);
        @(posedge clk); #1;
        check({tag, "_abort_nodone"}, {63'd0, done}, 64'd0);
        fin = 1'b1;
      end else if (rdy) begin
        sum = sum + exp_w.pop_front();
        void'(exp_i.pop_front());
        acc++;
        if (exp_w.size() == 0) begin
          check({tag, "_end_valid"}, {63'd0, dout_valid}, 64'd0);
          check({tag, "_done"}, {63'd0, done}, 64'd1);
          check({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
          check({tag, "_chk"}, chk, sum);
          @(posedge clk); #1;
          check({tag, "_done_clear"}, {63'd0, done}, 64'd0);
          check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
          check({tag, "_idle_chk"}, chk, sum);
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int fst, c, n, ab;
    rst_b = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
    first = '0; cnt = '0;
    q = {16{$urandom}};
    #20;
    check_zero("reset");
    #5 rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid", {63'd0, dout_valid}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    set_incr();
    run(0, 8, 0, 16'h0, -1, 1'b0, "basic");
    run(6, 4, 0, 16'h0, -1, 1'b0, "wrap4");
    run(6, 0, 0, 16'h0, -1, 1'b0, "wrap0");
    run(3, 12, 0, 16'h0, -1, 1'b0, "clamp");
    run(2, 3, 1, 16'h0034, -1, 1'b0, "bpress");
    run(1, 8, 0, 16'h0, -1, 1'b1, "snap");
    run(0, 5, 0, 16'h0, 2, 1'b0, "abort");
    run(4, 2, 0, 16'h0, -1, 1'b0, "after_abort");

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) regs[i] = {$urandom, $urandom};
      fst = $urandom_range(0, 7);
      c   = $urandom_range(0, 15);
      n   = (c == 0 || c > 8) ? 8 : c;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run(fst, c, 2, 16'h0, ab, 1'b0, "rand");
    end

    set_incr();
    load_q();
    first = 3'd0; cnt = 4'd8; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    check_zero("midreset");
    dout_ready = 1'b0;
    #11 rst_b = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("midreset_nodone", {63'd0, done}, 64'd0);
      check("midreset_valid", {63'd0, dout_valid}, 64'd0);
    end
    run(5, 3, 0, 16'h0, -1, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfl_rd_ser.md
Name: regfl_rd_ser

Overview:
- Downstream consumer of the 8x64 register file.
- Takes the flat 512-bit register-file output bus and, on a start command, captures a snapshot of it.
- Streams a selected run of registers as 64-bit words over a valid/ready interface, with wrap-around indexing.
- Produces a running modulo-2^W checksum of the words sent and a one-cycle done pulse.

Parameters:
- W, 64, width of one register / output word
- N, 8, number of registers on the flat bus (power of two; index width IW = log2(N) = 3)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_b  input  1  reset, asynchronous, active-low
- q  input  N*W (512)  flat register-file bus; register i occupies bits [N*W-1-i*W : N*W-W-i*W], so register 0 = q[511:448]
- start  input  1  begin a transfer; sampled only in IDLE
- first  input  IW (3)  index of the first register to send; sampled with start
- cnt  input  IW+1 (4)  number of words to send; 0 means N; values above N are clamped to N
- abort  input  1  cancel the transfer in progress
- dout  output  W  current output word
- dout_idx  output  IW  register index of dout
- dout_valid  output  1  dout/dout_idx valid
- dout_ready  input  1  consumer accepts the word
- busy  output  1  high in SEND and DONE
- done  output  1  one-cycle pulse after the last word is accepted
- chk  output  W  sum mod 2^W of the words accepted in the last or current transfer

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE; dout=0, dout_idx=0, dout_valid=0, busy=0, done=0, chk=0; snapshot buffer=0.
- All outputs are registered; there is no combinational path from input to output.
- States: IDLE, SEND, DONE.
- IDLE:
  - If start=1 at a posedge, the same edge captures all N words of q into the snapshot, latches idx=first and rem=effective cnt, and clears chk to 0.
  - The next state is SEND. From the next cycle: dout_valid=1, dout=snap[first], dout_idx=first, busy=1.
  - abort is ignored in IDLE.
- SEND:
  - A transfer occurs at a posedge with dout_valid=1 and dout_ready=1.
  - On transfer: chk <= chk + dout (truncated to W bits); idx <= (idx+1) mod N (wraps 7 -> 0); rem <= rem-1.
  - If more words remain, dout/dout_idx present the next word in the following cycle, so back-to-back transfers give one word per cycle.
  - While dout_valid=1 and dout_ready=0, dout and dout_idx are held stable.
  - When the transfer takes rem from 1 to 0, the next state is DONE and dout_valid=0.
- DONE: done=1 for exactly one cycle, busy=1, chk holds the final sum. Next state is IDLE, with busy=0 and done=0.
- Snapshot isolation: changes on q after the start edge do not affect words sent. A new transfer re-captures q.
- start while busy is ignored; it is not queued.
- abort in SEND (takes priority over a simultaneous transfer):
  - Next state is IDLE; dout_valid=0, busy=0, done is not pulsed.
  - chk holds its value from before that edge; the word offered on the abort edge is not counted.
- abort in DONE: ignored; the done pulse still occurs.
- Latency: start edge -> first dout_valid at the next cycle. Last accept -> done pulse at the next cycle. Minimum transfer of k words with dout_ready held at 1 occupies k SEND cycles plus 1 DONE cycle.
- cnt=0 and cnt>N both yield N words; the wrap-around covers all registers exactly once.
- Reset asserted mid-transfer returns everything to reset values immediately; no done pulse.
- chk remains readable in IDLE until the next accepted start.

Test Plan:
- Reset then idle: rst_b low for 25 time units, q=arbitrary -> all outputs 0, dout_valid stays 0 with start=0.
- Basic run: reg i = i+1 (q[511:448]=1 ... q[63:0]=8); start with first=0, cnt=8, ready=1 -> words 1..8 on 8 consecutive cycles with dout_idx 0..7, then done pulse, chk=36.
- Wrap and count: first=6, cnt=4, ready=1 -> idx 6,7,0,1, data 7,8,1,2, chk=18. Repeat with cnt=0 -> 8 words starting at idx 6, chk=36.
- Backpressure: first=2, cnt=3, ready toggling 0,0,1,0,1,1 -> each word is held stable while ready=0, sequence 3,4,5, chk=12, done exactly one cycle after the 3rd accept.
- Snapshot and ignored start: start a transfer, then change q to all 0xFF..FF and pulse start mid-transfer -> original values are still sent, no restart, one done pulse.
- Abort and reset: abort after 2 of 5 accepted words (data 1,2) -> dout_valid falls next cycle, no done, chk=3. A new transfer then runs normally. Finally, rst_b pulsed low mid-transfer -> immediate zeros, no done.
